// File: rtl/hazard_unit.sv
// Pipeline hazard controller: operand forwarding selects, load-use stall,
// branch flush, and saturating stall/flush event counters.
module hazard_unit #(
  parameter int CNT_W  = 16,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] RS1D,
  input  logic [REG_AW-1:0] RS2D,
  input  logic [REG_AW-1:0] RS1E,
  input  logic [REG_AW-1:0] RS2E,
  input  logic [REG_AW-1:0] RDE,
  input  logic              RegWriteE,
  input  logic              ResultSrcE,
  input  logic              PCSrcE,
  input  logic              CntClr,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [REG_AW-1:0] rd_m_r;
  logic [REG_AW-1:0] rd_w_r;
  logic              rw_m_r;
  logic              rw_w_r;
  logic              lw_s;

  // Memory stage wins over Writeback; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rdm,
    input logic              rwm,
    input logic [REG_AW-1:0] rdw,
    input logic              rww
  );
    if (rwm && (rdm != REG_ZERO) && (rdm == rs)) begin
      return 2'b10;
    end else if (rww && (rdw != REG_ZERO) && (rdw == rs)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  // Shadow copy of the Memory/Writeback destination fields; never stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_m_r <= REG_ZERO;
      rw_m_r <= 1'b0;
      rd_w_r <= REG_ZERO;
      rw_w_r <= 1'b0;
    end else begin
      rd_m_r <= RDE;
      rw_m_r <= RegWriteE;
      rd_w_r <= rd_m_r;
      rw_w_r <= rw_m_r;
    end
  end

  // Forward selects and stall/flush controls, held at 0 while in reset.
  always_comb begin
    lw_s      = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    if (rst) begin
      lw_s      = ResultSrcE & RegWriteE & (RDE != REG_ZERO) &
                  ((RDE == RS1D) | (RDE == RS2D));
      ForwardAE = fwd_sel(RS1E, rd_m_r, rw_m_r, rd_w_r, rw_w_r);
      ForwardBE = fwd_sel(RS2E, rd_m_r, rw_m_r, rd_w_r, rw_w_r);
      // A taken branch squashes Decode anyway, so it cancels the stall.
      StallF    = lw_s & ~PCSrcE;
      StallD    = lw_s & ~PCSrcE;
      FlushD    = PCSrcE;
      FlushE    = lw_s | PCSrcE;
    end else begin
      lw_s = 1'b0;
    end
  end

  // Saturating event counters; clear takes priority over counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      StallCnt <= CNT_ZERO;
      FlushCnt <= CNT_ZERO;
    end else if (CntClr) begin
      StallCnt <= CNT_ZERO;
      FlushCnt <= CNT_ZERO;
    end else begin
      if (StallF && (StallCnt != CNT_MAX)) begin
        StallCnt <= StallCnt + CNT_ONE;
      end else begin
        StallCnt <= StallCnt;
      end
      if (PCSrcE && (FlushCnt != CNT_MAX)) begin
        FlushCnt <= FlushCnt + CNT_ONE;
      end else begin
        FlushCnt <= FlushCnt;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: expected control vectors are queued as
// stimulus is driven and popped when the outputs are sampled.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] RS1D, RS2D, RS1E, RS2E, RDE;
  logic       RegWriteE, ResultSrcE, PCSrcE, CntClr;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, FlushD, FlushE;
  logic [3:0] StallCnt, FlushCnt;

  hazard_unit #(.CNT_W(4), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .RS1D(RS1D), .RS2D(RS2D), .RS1E(RS1E), .RS2E(RS2E), .RDE(RDE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .CntClr(CntClr),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
    logic       rwe, rse, pcs, clr;
    logic [1:0] fa, fb;
    logic       sf, fd, fe;
  } vec_t;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic       sf, sd, fd, fe;
    logic [3:0] sc, fc;
  } exp_t;

  exp_t exp_q[$];
  vec_t cur;
  logic [3:0] m_sc = 4'd0;
  logic [3:0] m_fc = 4'd0;
  int vectors = 0;
  int fails   = 0;

  function automatic vec_t mk(
    input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde,
    input logic rwe, rse, pcs, clr,
    input logic [1:0] fa, fb,
    input logic sf, fd, fe);
    vec_t v;
    v = {rs1d, rs2d, rs1e, rs2e, rde, rwe, rse, pcs, clr, fa, fb, sf, fd, fe};
    return v;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o = {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, StallCnt, FlushCnt};
    return o;
  endfunction

  task automatic drive(input vec_t v);
    RS1D = v.rs1d; RS2D = v.rs2d; RS1E = v.rs1e; RS2E = v.rs2e; RDE = v.rde;
    RegWriteE = v.rwe; ResultSrcE = v.rse; PCSrcE = v.pcs; CntClr = v.clr;
    cur = v;
    exp_q.push_back({v.fa, v.fb, v.sf, v.sf, v.fd, v.fe, m_sc, m_fc});
  endtask

  // Advance one clock and update the bench's own counter expectations.
  task automatic step();
    @(posedge clk);
    if (!rst || cur.clr) begin
      m_sc = 4'd0;
      m_fc = 4'd0;
    end else begin
      if (cur.sf && m_sc != 4'd15) m_sc = m_sc + 4'd1;
      if (cur.pcs && m_fc != 4'd15) m_fc = m_fc + 4'd1;
    end
    #1;
  endtask

  task automatic test_reset();
    vec_t t[$];
    exp_t e, o;
    t.push_back(mk(0, 0, 5, 0, 5, 1, 1, 1, 0, 2'b00, 2'b00, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    t.push_back(mk(0, 0, 5, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0));
    t.push_back(mk(0, 0, 5, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0));
    t.push_back(mk(0, 0, 5, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    foreach (t[i]) begin
      drive(t[i]);
      #2;
      e = exp_q.pop_front();
      o = observed();
      vectors++;
      if (o !== e) begin
        fails++;
        $display("FAIL reset[%0d] got %b expected %b", i, o, e);
      end
      step();
      if (i == 0) rst = 1'b1;
    end
  endtask

  task automatic test_forward();
    vec_t t[$];
    exp_t e, o;
    t.push_back(mk(0, 0, 0, 0, 3, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    t.push_back(mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 2'b10, 2'b10, 0, 0, 0));
    t.push_back(mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 0));
    t.push_back(mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    foreach (t[i]) begin
      drive(t[i]);
      #2;
      e = exp_q.pop_front();
      o = observed();
      vectors++;
      if (o !== e) begin
        fails++;
        $display("FAIL forward[%0d] got %b expected %b", i, o, e);
      end
      step();
    end
  endtask

  task automatic test_priority();
    vec_t t[$];
    exp_t e, o;
    t.push_back(mk(0, 0, 0, 0, 4, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 4, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    t.push_back(mk(0, 0, 4, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0));
    t.push_back(mk(0, 0, 4, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    foreach (t[i]) begin
      drive(t[i]);
      #2;
      e = exp_q.pop_front();
      o = observed();
      vectors++;
      if (o !== e) begin
        fails++;
        $display("FAIL priority[%0d] got %b expected %b", i, o, e);
      end
      step();
    end
  endtask

  task automatic test_load_use();
    vec_t t[$];
    exp_t e, o;
    t.push_back(mk(0, 7, 0, 0, 7, 1, 1, 0, 0, 2'b00, 2'b00, 1, 0, 1));
    t.push_back(mk(0, 7, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 7, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    t.push_back(mk(7, 0, 0, 0, 7, 1, 1, 0, 0, 2'b00, 2'b00, 1, 0, 1));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    t.push_back(mk(7, 0, 0, 0, 7, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    foreach (t[i]) begin
      drive(t[i]);
      #2;
      e = exp_q.pop_front();
      o = observed();
      vectors++;
      if (o !== e) begin
        fails++;
        $display("FAIL load_use[%0d] got %b expected %b", i, o, e);
      end
      step();
    end
  endtask

  task automatic test_branch();
    vec_t t[$];
    exp_t e, o;
    t.push_back(mk(9, 0, 0, 0, 9, 1, 1, 1, 0, 2'b00, 2'b00, 0, 1, 1));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    foreach (t[i]) begin
      drive(t[i]);
      #2;
      e = exp_q.pop_front();
      o = observed();
      vectors++;
      if (o !== e) begin
        fails++;
        $display("FAIL branch[%0d] got %b expected %b", i, o, e);
      end
      step();
    end
  endtask

  task automatic test_saturate();
    vec_t t[$];
    exp_t e, o;
    for (int k = 0; k < 20; k++)
      t.push_back(mk(0, 7, 0, 0, 7, 1, 1, 0, 0, 2'b00, 2'b00, 1, 0, 1));
    for (int k = 0; k < 16; k++)
      t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 1, 1));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    t.push_back(mk(0, 7, 0, 0, 7, 1, 1, 1, 1, 2'b00, 2'b00, 0, 1, 1));
    t.push_back(mk(0, 7, 0, 0, 7, 1, 1, 0, 1, 2'b00, 2'b00, 1, 0, 1));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    foreach (t[i]) begin
      drive(t[i]);
      #2;
      e = exp_q.pop_front();
      o = observed();
      vectors++;
      if (o !== e) begin
        fails++;
        $display("FAIL saturate[%0d] got %b expected %b", i, o, e);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_stall();
    exp_t e, o;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    #2;
    e = exp_q.pop_front();
    o = observed();
    vectors++;
    if (o !== e) begin
      fails++;
      $display("FAIL mid_reset_pre got %b expected %b", o, e);
    end
    step();
    drive(mk(0, 7, 0, 0, 7, 1, 1, 0, 0, 2'b00, 2'b00, 1, 0, 1));
    #2;
    e = exp_q.pop_front();
    o = observed();
    vectors++;
    if (o !== e) begin
      fails++;
      $display("FAIL mid_reset_stall got %b expected %b", o, e);
    end
    rst = 1'b0;
    m_sc = 4'd0;
    m_fc = 4'd0;
    exp_q.push_back(14'd0);
    #1;
    e = exp_q.pop_front();
    o = observed();
    vectors++;
    if (o !== e) begin
      fails++;
      $display("FAIL mid_reset_async got %b expected %b", o, e);
    end
    step();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    RS1D = 5'd0; RS2D = 5'd0; RS1E = 5'd0; RS2E = 5'd0; RDE = 5'd0;
    RegWriteE = 1'b0; ResultSrcE = 1'b0; PCSrcE = 1'b0; CntClr = 1'b0;
    test_reset();
    test_forward();
    test_priority();
    test_load_use();
    test_branch();
    test_saturate();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t, bench did not complete", $time);
    $fatal(1);
  end

endmodule
